// File: rtl/data_type_pkg.sv
// Shared bfloat16 field widths, divider constants and FSM state encoding.
package data_type_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 7;
  localparam int BIAS     = 127;
  localparam int DIV_ITER = 9;

  localparam logic [EXP_W-1:0]  EXP_MAX   = 8'hFF;
  localparam logic [FRAC_W-1:0] QNAN_FRAC = 7'h40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_div_frac_div.sv
// Iterative restoring mantissa divider: one quotient bit per cycle.
// The first iteration (bit 8) is taken on the start edge itself using the
// incoming operands, so all DIV_ITER bits are known DIV_ITER-1 edges later,
// when o_done pulses for one cycle.
module frac_div
  import data_type_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [FRAC_W:0]     i_dividend,
  input  logic [FRAC_W:0]     i_divisor,
  output logic [DIV_ITER-1:0] o_q,
  output logic                o_done
);

  logic [9:0]          r_rem;
  logic [FRAC_W:0]     r_div;
  logic [DIV_ITER-1:0] r_q;
  logic [3:0]          r_cnt;
  logic                r_busy;
  logic                r_done;

  logic [9:0]      w_rem_in;
  logic [FRAC_W:0] w_div_in;
  logic            w_ge;
  logic [9:0]      w_rem_next;

  // One restoring step on either the fresh operands or the running remainder.
  always_comb begin
    w_rem_in   = i_start ? {2'b00, i_dividend} : r_rem;
    w_div_in   = i_start ? i_divisor : r_div;
    w_ge       = (w_rem_in >= {2'b00, w_div_in});
    w_rem_next = (w_ge ? (w_rem_in - {2'b00, w_div_in}) : w_rem_in) << 1;
  end

  // Iteration counter, remainder and quotient shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_rem_next;
        r_div  <= i_divisor;
        r_q    <= {{(DIV_ITER-1){1'b0}}, w_ge};
        r_cnt  <= 4'(DIV_ITER - 2);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_rem_next;
        r_q   <= {r_q[DIV_ITER-2:0], w_ge};
        if (r_cnt == 4'd0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign o_q    = r_q;
  assign o_done = r_done;

endmodule

// File: rtl/fp_div.sv
// bfloat16 divider: FSM, special-operand handling, exponent arithmetic and
// registered result. Handshake: a transfer happens at a clock edge where
// valid && ready are both high; in_ready is high only in IDLE, and the
// result is held stable while out_valid is high until out_ready is seen.
module fp_div
  import data_type_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op1_sign,
  input  logic [EXP_W-1:0]  op1_exp,
  input  logic [FRAC_W-1:0] op1_frac,
  input  logic              op2_sign,
  input  logic [EXP_W-1:0]  op2_exp,
  input  logic [FRAC_W-1:0] op2_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              op3_sign,
  output logic [EXP_W-1:0]  op3_exp,
  output logic [FRAC_W-1:0] op3_frac,
  output logic              overflow,
  output logic              underflow,
  output logic              div_by_zero,
  output logic [1:0]        dbg_state
);

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_sign;
  logic [EXP_W-1:0]    r_exp;
  logic [FRAC_W-1:0]   r_frac;
  logic                r_ovf;
  logic                r_unf;
  logic                r_dbz;
  logic signed [9:0]   r_e_base;

  logic                w_accept;
  logic                w_nan;
  logic                w_op2_zero;
  logic                w_op1_zero;
  logic                w_start;
  logic signed [9:0]   w_e_base;
  logic signed [9:0]   w_e;
  logic [DIV_ITER-1:0] w_q;
  logic                w_done;
  logic [FRAC_W-1:0]   w_frac_norm;

  // Operand classification and exponent arithmetic; exp==0 means zero.
  always_comb begin
    w_accept    = in_valid && r_in_ready;
    w_nan       = (op1_exp == EXP_MAX) || (op2_exp == EXP_MAX);
    w_op2_zero  = (op2_exp == '0);
    w_op1_zero  = (op1_exp == '0);
    w_start     = w_accept && !w_nan && !w_op2_zero && !w_op1_zero;
    w_e_base    = $signed({2'b00, op1_exp}) - $signed({2'b00, op2_exp}) + 10'sd127;
    w_e         = r_e_base - $signed({9'b0, ~w_q[8]});
    w_frac_norm = w_q[8] ? w_q[7:1] : w_q[6:0];
  end

  frac_div u_frac_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_dividend ({1'b1, op1_frac}),
    .i_divisor  ({1'b1, op2_frac}),
    .o_q        (w_q),
    .o_done     (w_done)
  );

  // Control FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_frac      <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_dbz       <= 1'b0;
      r_e_base    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_sign     <= op1_sign ^ op2_sign;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_dbz      <= 1'b0;
            if (w_nan) begin
              r_exp       <= EXP_MAX;
              r_frac      <= QNAN_FRAC;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_op2_zero) begin
              r_exp       <= EXP_MAX;
              r_frac      <= '0;
              r_dbz       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_op1_zero) begin
              r_exp       <= '0;
              r_frac      <= '0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_e_base <= w_e_base;
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          if (w_done) begin
            if (w_e >= 10'sd255) begin
              r_exp <= EXP_MAX;
              r_frac <= '0;
              r_ovf <= 1'b1;
            end else if (w_e <= 10'sd0) begin
              r_exp <= '0;
              r_frac <= '0;
              r_unf <= 1'b1;
            end else begin
              r_exp  <= w_e[7:0];
              r_frac <= w_frac_norm;
            end
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign op3_sign    = r_sign;
  assign op3_exp     = r_exp;
  assign op3_frac    = r_frac;
  assign overflow    = r_ovf;
  assign underflow   = r_unf;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fp_div.sv
// Directed-vector bench for the bfloat16 divider.
module tb_fp_div;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       op1_sign, op2_sign;
  logic [7:0] op1_exp, op2_exp;
  logic [6:0] op1_frac, op2_frac;
  logic       out_valid;
  logic       out_ready;
  logic       op3_sign;
  logic [7:0] op3_exp;
  logic [6:0] op3_frac;
  logic       overflow, underflow, div_by_zero;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fp_div dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op1_sign    (op1_sign),
    .op1_exp     (op1_exp),
    .op1_frac    (op1_frac),
    .op2_sign    (op2_sign),
    .op2_exp     (op2_exp),
    .op2_frac    (op2_frac),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .op3_sign    (op3_sign),
    .op3_exp     (op3_exp),
    .op3_frac    (op3_frac),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operand pair and hold in_valid across exactly one edge.
  task automatic send(input logic s1, input logic [7:0] e1, input logic [6:0] f1,
                      input logic s2, input logic [7:0] e2, input logic [6:0] f2);
    op1_sign = s1; op1_exp = e1; op1_frac = f1;
    op2_sign = s2; op2_exp = e2; op2_frac = f2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Full transaction with expected quotient, flags and latency.
  // Normal ops: out_valid is seen by edge k+10, i.e. set 9 edges after accept.
  // Special ops: seen by edge k+1, i.e. set on the accept edge itself.
  task automatic run_op(input string tag,
                        input logic s1, input logic [7:0] e1, input logic [6:0] f1,
                        input logic s2, input logic [7:0] e2, input logic [6:0] f2,
                        input logic xs, input logic [7:0] xe, input logic [6:0] xf,
                        input logic xov, input logic xun, input logic xdz, input int xlat);
    int lat;
    send(s1, e1, f1, s2, e2, f2);
    wait_valid(lat);
    check({tag, ".lat"},  lat,         xlat);
    check({tag, ".sign"}, op3_sign,    xs);
    check({tag, ".exp"},  op3_exp,     xe);
    check({tag, ".frac"}, op3_frac,    xf);
    check({tag, ".ovf"},  overflow,    xov);
    check({tag, ".unf"},  underflow,   xun);
    check({tag, ".dbz"},  div_by_zero, xdz);
    release_result();
    check({tag, ".vld_clr"}, out_valid, 1'b0);
    check({tag, ".rdy_ret"}, in_ready,  1'b1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op1_sign = 0; op1_exp = 0; op1_frac = 0;
    op2_sign = 0; op2_exp = 0; op2_frac = 0;
    #12;
    check("rst.in_ready",  in_ready,  1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.op3",       {op3_sign, op3_exp, op3_frac}, 16'h0000);
    check("rst.flags",     {overflow, underflow, div_by_zero}, 3'b000);
    check("rst.state",     dbg_state, 2'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    //      tag      s1 e1     f1     s2 e2     f2     xs xe     xf     ov un dz lat
    run_op("one",    0, 8'h7F, 7'h00, 0, 8'h7F, 7'h00, 0, 8'h7F, 7'h00, 0, 0, 0, 9);
    run_op("3by2",   0, 8'h80, 7'h40, 0, 8'h80, 7'h00, 0, 8'h7F, 7'h40, 0, 0, 0, 9);
    run_op("1byn3",  0, 8'h7F, 7'h00, 1, 8'h80, 7'h40, 1, 8'h7D, 7'h2A, 0, 0, 0, 9);
    run_op("7o5",    0, 8'h7F, 7'h60, 0, 8'h7F, 7'h20, 0, 8'h7F, 7'h33, 0, 0, 0, 9);
    run_op("ovf",    0, 8'hFE, 7'h00, 0, 8'h01, 7'h00, 0, 8'hFF, 7'h00, 1, 0, 0, 9);
    run_op("unf",    0, 8'h01, 7'h00, 0, 8'hFE, 7'h00, 0, 8'h00, 7'h00, 0, 1, 0, 9);
    run_op("e255",   1, 8'hFE, 7'h00, 1, 8'h7E, 7'h00, 0, 8'hFF, 7'h00, 1, 0, 0, 9);
    run_op("e1",     0, 8'h01, 7'h00, 0, 8'h7F, 7'h00, 0, 8'h01, 7'h00, 0, 0, 0, 9);
    run_op("e0adj",  0, 8'h01, 7'h00, 0, 8'h7F, 7'h40, 0, 8'h00, 7'h00, 0, 1, 0, 9);
    run_op("5by0",   0, 8'h81, 7'h20, 0, 8'h00, 7'h00, 0, 8'hFF, 7'h00, 0, 0, 1, 0);
    run_op("nan",    1, 8'hFF, 7'h40, 0, 8'h7F, 7'h00, 1, 8'hFF, 7'h40, 0, 0, 0, 0);
    run_op("nanby0", 0, 8'hFF, 7'h00, 1, 8'h00, 7'h00, 1, 8'hFF, 7'h40, 0, 0, 0, 0);
    run_op("0by5",   1, 8'h00, 7'h00, 0, 8'h81, 7'h20, 1, 8'h00, 7'h00, 0, 0, 0, 0);

    // Back-pressure: result held, new operands ignored while busy.
    send(0, 8'h80, 7'h40, 0, 8'h80, 7'h00);
    wait_valid(lat);
    check("hold.lat", lat, 9);
    op1_exp = 8'h7F; op1_frac = 7'h00; op2_exp = 8'h7F; op2_frac = 7'h00;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold.valid",    out_valid, 1'b1);
      check("hold.in_ready", in_ready,  1'b0);
      check("hold.result",   {op3_sign, op3_exp, op3_frac}, {1'b0, 8'h7F, 7'h40});
    end
    in_valid = 1'b0;
    release_result();
    repeat (12) @(posedge clk);
    #1;
    check("hold.no_extra", out_valid, 1'b0);
    check("hold.idle",     in_ready,  1'b1);

    // Reset in the middle of CALC aborts the operation.
    send(0, 8'h7F, 7'h00, 0, 8'h7F, 7'h00);
    repeat (3) @(posedge clk);
    #2;
    check("abort.in_calc", dbg_state, 2'd1);
    rst_n = 1'b0;
    #1;
    check("abort.valid",    out_valid, 1'b0);
    check("abort.in_ready", in_ready,  1'b1);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort.no_result", out_valid, 1'b0);
    run_op("recover", 0, 8'h7F, 7'h00, 1, 8'h80, 7'h40, 1, 8'h7D, 7'h2A, 0, 0, 0, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
